// File: rtl/tia_clock_divider_if.sv
// Control and status bundle between the phase generator and its consumers.
// The master side drives the controls. The slave side is the divider itself.
interface tia_clock_divider_if #(
  parameter int DIV_WIDTH = 4
) ();

  logic                 enable;
  logic                 rsyn;
  logic                 div_load;
  logic [DIV_WIDTH-1:0] div_ratio;
  logic [DIV_WIDTH-1:0] phase;
  logic                 phi1_stb;
  logic                 phi2_stb;
  logic                 div_out;
  logic                 rsyn_gated;

  modport master (
    output enable,
    output rsyn,
    output div_load,
    output div_ratio,
    input  phase,
    input  phi1_stb,
    input  phi2_stb,
    input  div_out,
    input  rsyn_gated
  );

  modport slave (
    input  enable,
    input  rsyn,
    input  div_load,
    input  div_ratio,
    output phase,
    output phi1_stb,
    output phi2_stb,
    output div_out,
    output rsyn_gated
  );

endinterface

// File: rtl/tia_clock_divider.sv
// Programmable-ratio phase generator for the TIA/CPU clock phases.
// A new ratio is queued and only takes effect at a wrap or a resync.
module tia_clock_divider #(
  parameter int DIV_WIDTH   = 4,
  parameter int RESET_RATIO = 3
) (
  input  logic                    clk,
  input  logic                    resphi0_n,
  tia_clock_divider_if.slave      bus
);

  localparam logic [DIV_WIDTH-1:0] ZERO      = DIV_WIDTH'(1'b0);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1'b1);
  localparam logic [DIV_WIDTH-1:0] TWO       = DIV_WIDTH'(2'd2);
  localparam logic [DIV_WIDTH-1:0] RST_RATIO =
    (RESET_RATIO < 2) ? TWO : DIV_WIDTH'(RESET_RATIO);

  // Ratios of 0 and 1 cannot produce two distinct phases, so they become 2.
  function automatic logic [DIV_WIDTH-1:0] clamp_ratio(input logic [DIV_WIDTH-1:0] r);
    if (r < TWO) begin
      return TWO;
    end else begin
      return r;
    end
  endfunction

  logic [DIV_WIDTH-1:0] phase_q,   phase_d;
  logic [DIV_WIDTH-1:0] active_q,  active_d;
  logic [DIV_WIDTH-1:0] pending_q, pending_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 phi1_q,    phi1_d;
  logic                 phi2_q,    phi2_d;
  logic                 div_out_q, div_out_d;

  logic [DIV_WIDTH-1:0] nxt_s;
  logic [DIV_WIDTH-1:0] half_s;
  logic                 decode_s;
  logic                 apply_s;

  // Next phase, ratio hand-over and strobe decode of the next phase.
  always_comb begin
    nxt_s           = phase_q;
    decode_s        = 1'b0;
    apply_s         = 1'b0;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    phi1_d          = 1'b0;
    phi2_d          = 1'b0;
    div_out_d       = 1'b0;
    half_s          = ZERO;

    if (bus.rsyn) begin
      nxt_s    = ZERO;
      decode_s = 1'b1;
      apply_s  = pending_valid_q;
    end else if (!bus.enable) begin
      nxt_s    = phase_q;
      decode_s = 1'b0;
    end else if (phase_q >= (active_q - ONE)) begin
      // The >= also recovers an out-of-range phase on the next enabled edge.
      nxt_s    = ZERO;
      decode_s = 1'b1;
      apply_s  = pending_valid_q;
    end else begin
      nxt_s    = phase_q + ONE;
      decode_s = 1'b1;
    end

    if (apply_s) begin
      active_d = pending_q;
    end else begin
      active_d = active_q;
    end

    // A load on the hand-over edge is queued behind the value just applied.
    if (bus.div_load) begin
      pending_d       = clamp_ratio(bus.div_ratio);
      pending_valid_d = 1'b1;
    end else if (apply_s) begin
      pending_d       = pending_q;
      pending_valid_d = 1'b0;
    end else begin
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
    end

    half_s = active_d >> 1;
    if (decode_s) begin
      phi1_d    = (nxt_s == (active_d - ONE));
      phi2_d    = (nxt_s == (half_s - ONE));
      div_out_d = (nxt_s < half_s);
    end else begin
      phi1_d    = 1'b0;
      phi2_d    = 1'b0;
      div_out_d = 1'b0;
    end

    phase_d = nxt_s;
  end

  // State register; resphi0_n clears everything asynchronously.
  always_ff @(posedge clk or negedge resphi0_n) begin
    if (!resphi0_n) begin
      phase_q         <= ZERO;
      active_q        <= RST_RATIO;
      pending_q       <= RST_RATIO;
      pending_valid_q <= 1'b0;
      phi1_q          <= 1'b0;
      phi2_q          <= 1'b0;
      div_out_q       <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      phi1_q          <= phi1_d;
      phi2_q          <= phi2_d;
      div_out_q       <= div_out_d;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.phi1_stb   = phi1_q;
  assign bus.phi2_stb   = phi2_q;
  assign bus.div_out    = div_out_q;
  assign bus.rsyn_gated = bus.rsyn & ~phi1_q;

endmodule

// File: tb/tb_tia_clock_divider.sv
// Directed bench for tia_clock_divider: expected vectors are {phase, phi1, phi2, div_out}
// hand-derived for each ratio.
module tb_tia_clock_divider;

  logic clk;
  logic resphi0_n;
  int   total;
  int   bad;

  tia_clock_divider_if #(.DIV_WIDTH(4)) bus ();

  tia_clock_divider #(.DIV_WIDTH(4), .RESET_RATIO(3)) dut (
    .clk       (clk),
    .resphi0_n (resphi0_n),
    .bus       (bus)
  );

  logic [6:0] obs;
  assign obs = {bus.phase, bus.phi1_stb, bus.phi2_stb, bus.div_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resphi0_n     = 1'b0;
    bus.enable    = 1'b0;
    bus.rsyn      = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_ratio = 4'd0;
    step();
    step();
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0000_000);
    end
    total++;
    if (bus.rsyn_gated !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsyn_gated got=%b exp=0", bus.rsyn_gated);
    end
    bus.rsyn = 1'b1;
    #1;
    total++;
    if (bus.rsyn_gated !== 1'b1) begin
      bad++;
      $display("FAIL reset_rsyn_pass got=%b exp=1", bus.rsyn_gated);
    end
    bus.rsyn = 1'b0;
    @(negedge clk);
    resphi0_n  = 1'b1;
    bus.enable = 1'b1;
  endtask

  task automatic test_divide_by_three();
    logic [6:0] n3 [3] = '{7'b0000_011, 7'b0001_000, 7'b0010_100};
    for (int i = 1; i <= 30; i++) begin
      step();
      total++;
      if (obs !== n3[i % 3]) begin
        bad++;
        $display("FAIL div3_seq cyc=%0d got=%b exp=%b", i, obs, n3[i % 3]);
      end
      total++;
      if ((bus.phi1_stb & bus.phi2_stb) !== 1'b0) begin
        bad++;
        $display("FAIL div3_overlap cyc=%0d got=1 exp=0", i);
      end
    end
  endtask

  task automatic test_ratio_load();
    logic [6:0] seq [8] = '{7'b0001_000, 7'b0010_100, 7'b0000_001, 7'b0001_011,
                            7'b0010_000, 7'b0011_000, 7'b0100_100, 7'b0000_001};
    bus.div_ratio = 4'd5;
    bus.div_load  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.div_load = 1'b0;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL load5_seq idx=%0d got=%b exp=%b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [6:0] seq [9] = '{7'b0001_011, 7'b0010_000,
                            7'b0010_000, 7'b0010_000, 7'b0010_000, 7'b0010_000,
                            7'b0011_000, 7'b0100_100, 7'b0000_001};
    for (int i = 0; i < 9; i++) begin
      bus.enable = !(i >= 2 && i < 6);
      step();
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL enable_hold idx=%0d got=%b exp=%b", i, obs, seq[i]);
      end
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_rsyn();
    logic [6:0] pre [3] = '{7'b0001_011, 7'b0010_000, 7'b0011_000};
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== pre[i]) begin
        bad++;
        $display("FAIL rsyn_pre idx=%0d got=%b exp=%b", i, obs, pre[i]);
      end
    end
    bus.rsyn = 1'b1;
    #1;
    total++;
    if (bus.rsyn_gated !== 1'b1) begin
      bad++;
      $display("FAIL rsyn_gated_pass got=%b exp=1", bus.rsyn_gated);
    end
    step();
    bus.rsyn = 1'b0;
    total++;
    if (obs !== 7'b0000_001) begin
      bad++;
      $display("FAIL rsyn_restart got=%b exp=%b", obs, 7'b0000_001);
    end
    repeat (4) step();
    total++;
    if (obs !== 7'b0100_100) begin
      bad++;
      $display("FAIL rsyn_phi1_cycle got=%b exp=%b", obs, 7'b0100_100);
    end
    bus.rsyn = 1'b1;
    #1;
    total++;
    if (bus.rsyn_gated !== 1'b0) begin
      bad++;
      $display("FAIL rsyn_gated_block got=%b exp=0", bus.rsyn_gated);
    end
    step();
    bus.rsyn = 1'b0;
    total++;
    if (obs !== 7'b0000_001) begin
      bad++;
      $display("FAIL rsyn_at_phi1 got=%b exp=%b", obs, 7'b0000_001);
    end
    step();
    bus.enable = 1'b0;
    bus.rsyn   = 1'b1;
    step();
    bus.rsyn   = 1'b0;
    total++;
    if (bus.phase !== 4'd0) begin
      bad++;
      $display("FAIL rsyn_disabled got=%0d exp=0", bus.phase);
    end
    step();
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL rsyn_then_hold got=%b exp=%b", obs, 7'b0000_000);
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_clamp();
    logic [6:0] s0 [8] = '{7'b0001_011, 7'b0010_000, 7'b0011_000, 7'b0100_100,
                           7'b0000_011, 7'b0001_100, 7'b0000_011, 7'b0001_100};
    logic [6:0] s1 [4] = '{7'b0000_011, 7'b0001_100, 7'b0000_011, 7'b0001_100};
    bus.div_ratio = 4'd0;
    bus.div_load  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.div_load = 1'b0;
      total++;
      if (obs !== s0[i]) begin
        bad++;
        $display("FAIL clamp0_seq idx=%0d got=%b exp=%b", i, obs, s0[i]);
      end
    end
    bus.div_ratio = 4'd1;
    bus.div_load  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.div_load = 1'b0;
      total++;
      if (obs !== s1[i]) begin
        bad++;
        $display("FAIL clamp1_seq idx=%0d got=%b exp=%b", i, obs, s1[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s4 [7] = '{7'b0001_000, 7'b0010_100, 7'b0000_001, 7'b0001_011,
                           7'b0010_000, 7'b0011_100, 7'b0000_001};
    logic [6:0] s6 [6] = '{7'b0001_001, 7'b0010_011, 7'b0011_000, 7'b0100_000,
                           7'b0101_100, 7'b0000_011};
    bus.div_ratio = 4'd3;
    bus.div_load  = 1'b1;
    step();
    bus.div_load  = 1'b0;
    total++;
    if (obs !== 7'b0000_011) begin
      bad++;
      $display("FAIL b2b_queue3 got=%b exp=%b", obs, 7'b0000_011);
    end
    step();
    total++;
    if (obs !== 7'b0001_100) begin
      bad++;
      $display("FAIL b2b_still2 got=%b exp=%b", obs, 7'b0001_100);
    end
    bus.div_ratio = 4'd4;
    bus.div_load  = 1'b1;
    step();
    bus.div_load  = 1'b0;
    total++;
    if (obs !== 7'b0000_011) begin
      bad++;
      $display("FAIL b2b_wrap_load got=%b exp=%b", obs, 7'b0000_011);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (obs !== s4[i]) begin
        bad++;
        $display("FAIL b2b_seq idx=%0d got=%b exp=%b", i, obs, s4[i]);
      end
    end
    bus.div_ratio = 4'd6;
    bus.div_load  = 1'b1;
    step();
    bus.div_ratio = 4'd2;
    bus.rsyn      = 1'b1;
    step();
    bus.div_load  = 1'b0;
    bus.rsyn      = 1'b0;
    total++;
    if (obs !== 7'b0000_001) begin
      bad++;
      $display("FAIL rsyn_load_apply got=%b exp=%b", obs, 7'b0000_001);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (obs !== s6[i]) begin
        bad++;
        $display("FAIL rsyn_load_seq idx=%0d got=%b exp=%b", i, obs, s6[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] s3 [5] = '{7'b0001_000, 7'b0010_100, 7'b0000_011, 7'b0001_000, 7'b0010_100};
    bus.div_ratio = 4'd7;
    bus.div_load  = 1'b1;
    step();
    bus.div_load  = 1'b0;
    total++;
    if (obs !== 7'b0001_100) begin
      bad++;
      $display("FAIL areset_pre got=%b exp=%b", obs, 7'b0001_100);
    end
    #2;
    resphi0_n = 1'b0;
    #1;
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL areset_immediate got=%b exp=%b", obs, 7'b0000_000);
    end
    @(negedge clk);
    resphi0_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs !== s3[i]) begin
        bad++;
        $display("FAIL areset_post idx=%0d got=%b exp=%b", i, obs, s3[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_divide_by_three();
    test_ratio_load();
    test_enable_hold();
    test_rsyn();
    test_clamp();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
